// File: rtl/pipe_pkg.sv
// Shared widths, MEM/WB field offsets and occupancy encoding for the
// inter-stage pipeline registers.
package pipe_pkg;

  localparam int IFID_DATA_W  = 96;   // Instr, PC, PCPlus4
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 175;  // RD1, RD2, PC, ImmExt, PCPlus4, rs1, rs2, rd
  localparam int IDEX_CTRL_W  = 10;
  localparam int EXMEM_DATA_W = 101;  // ALUResult, WriteData, PCPlus4, rd
  localparam int EXMEM_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 101;  // ALUResult, ReadData, PCPlus4, rd
  localparam int MEMWB_CTRL_W = 3;

  localparam int MEMWB_ALURESULT_LSB = 0;
  localparam int MEMWB_ALURESULT_MSB = 31;
  localparam int MEMWB_READDATA_LSB  = 32;
  localparam int MEMWB_READDATA_MSB  = 63;
  localparam int MEMWB_PCPLUS4_LSB   = 64;
  localparam int MEMWB_PCPLUS4_MSB   = 95;
  localparam int MEMWB_RD_LSB        = 96;
  localparam int MEMWB_RD_MSB        = 100;

  localparam int MEMWB_REGWRITE_BIT   = 0;
  localparam int MEMWB_RESULTSRC_LSB  = 1;
  localparam int MEMWB_RESULTSRC_MSB  = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline register with optional 2-entry skid buffer,
// synchronous flush and bubble insertion (ctrl forced to zero when invalid).
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic in_acc;
  logic out_acc;
  occ_e occ;

  // With the skid buffer, in_ready comes straight off a flop so out_ready
  // never reaches the upstream stage combinationally.
  assign in_ready  = (SKID != 0) ? ~skid_valid_q : (~main_valid_q | out_ready);
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = main_valid_q & out_ready;
  assign occ       = occ_e'({1'b0, main_valid_q} + {1'b0, skid_valid_q});

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else if (flush) begin
      // Data is left in place; only valids and side-effecting ctrl are killed.
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (in_acc) begin
            main_valid_q <= 1'b1;
            main_data_q  <= in_data;
            main_ctrl_q  <= in_ctrl;
          end
        end
        OCC_ONE: begin
          if (in_acc && out_acc) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (in_acc) begin
            if (SKID != 0) begin
              skid_valid_q <= 1'b1;
              skid_data_q  <= in_data;
              skid_ctrl_q  <= in_ctrl;
            end
          end else if (out_acc) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
          end
        end
        OCC_TWO: begin
          if (out_acc) begin
            main_data_q  <= skid_data_q;
            main_ctrl_q  <= skid_ctrl_q;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
          end
        end
        default: begin
          main_valid_q <= 1'b0;
          main_ctrl_q  <= '0;
          skid_valid_q <= 1'b0;
          skid_ctrl_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: skid build (SKID=1) plus a
// pass-through build (SKID=0) sharing clock and reset.
module tb_pipe_skid_stage;

  localparam int DW = 101;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;

  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;

  logic          s0_in_valid, s0_in_ready, s0_flush, s0_out_valid, s0_out_ready;
  logic [DW-1:0] s0_in_data, s0_out_data;
  logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;
  logic [1:0]    s0_occupancy;

  int total = 0;
  int bad   = 0;
  logic [31:0] log_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
    .flush(s0_flush),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .out_ctrl(s0_out_ctrl), .occupancy(s0_occupancy)
  );

  // Record every downstream transfer of the skid build.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) log_q.push_back(out_data[31:0]);
  end

  function automatic logic [DW-1:0] mk(input logic [31:0] v);
    return {{(DW-32){1'b0}}, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = mk(32'hDEADBEEF); in_ctrl = 3'b111;
    out_ready = 1'b1; flush = 1'b0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    total++; if (out_ctrl !== 3'b000) begin bad++; $display("FAIL rst_out_ctrl got=%0h exp=0", out_ctrl); end
    total++; if (out_data !== mk(32'h0)) begin bad++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    rst = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== mk(32'hDEADBEEF) || out_ctrl !== 3'b111)
      begin bad++; $display("FAIL rst_first_accept got v=%0h d=%0h c=%0h exp v=1 d=deadbeef c=7", out_valid, out_data, out_ctrl); end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin bad++; $display("FAIL rst_drain got v=%0h occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_streaming();
    log_q.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = mk(32'(i)); in_ctrl = 3'b011;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%0h exp=1", i, in_ready); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== mk(32'(i)) || out_ctrl !== 3'b011)
        begin bad++; $display("FAIL stream_out[%0d] got v=%0h d=%0h c=%0h exp v=1 d=%0h c=3", i, out_valid, out_data, out_ctrl, i); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin bad++; $display("FAIL stream_drain got v=%0h occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    total++; if (log_q.size() !== 8) begin bad++; $display("FAIL stream_count got=%0d exp=8", log_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      total++; if (log_q[i] !== 32'(i + 1)) begin bad++; $display("FAIL stream_order[%0d] got=%0h exp=%0h", i, log_q[i], i + 1); end
    end
  endtask

  task automatic test_skid();
    log_q.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = mk(32'h10); in_ctrl = 3'b001;
    step();
    out_ready = 1'b0; in_data = mk(32'h20); in_ctrl = 3'b010;
    step();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL skid_occ2 got=%0d exp=2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_in_ready got=%0h exp=0", in_ready); end
    total++; if (out_data !== mk(32'h10) || out_ctrl !== 3'b001)
      begin bad++; $display("FAIL skid_hold got d=%0h c=%0h exp d=10 c=1", out_data, out_ctrl); end
    step();
    total++; if (occupancy !== 2'd2 || out_data !== mk(32'h10))
      begin bad++; $display("FAIL skid_stall got occ=%0d d=%0h exp occ=2 d=10", occupancy, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== mk(32'h20) || out_ctrl !== 3'b010 || occupancy !== 2'd1 || in_ready !== 1'b1)
      begin bad++; $display("FAIL skid_unload got v=%0h d=%0h c=%0h occ=%0d r=%0h exp v=1 d=20 c=2 occ=1 r=1", out_valid, out_data, out_ctrl, occupancy, in_ready); end
    step();
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL skid_drain got=%0d exp=0", occupancy); end
    total++; if (log_q.size() !== 2 || log_q[0] !== 32'h10 || log_q[1] !== 32'h20)
      begin bad++; $display("FAIL skid_order got n=%0d exp n=2 (10,20)", log_q.size()); end
  endtask

  task automatic test_flush();
    log_q.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = mk(32'h30); in_ctrl = 3'b111;
    step();
    out_ready = 1'b0; in_data = mk(32'h40);
    step();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = mk(32'h50);
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL flush_two got v=%0h c=%0h occ=%0d r=%0h exp v=0 c=0 occ=0 r=1", out_valid, out_ctrl, occupancy, in_ready); end
    total++; if (out_data !== mk(32'h30)) begin bad++; $display("FAIL flush_data_hold got=%0h exp=30", out_data); end
    in_valid = 1'b1; in_data = mk(32'h60); in_ctrl = 3'b101;
    step();
    flush = 1'b1; in_data = mk(32'h70);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_one_ready got=%0h exp=1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || occupancy !== 2'd0)
      begin bad++; $display("FAIL flush_one got v=%0h c=%0h occ=%0d exp v=0 c=0 occ=0", out_valid, out_ctrl, occupancy); end
    step(); step();
    total++; if (out_valid !== 1'b0 || log_q.size() !== 0)
      begin bad++; $display("FAIL flush_leak got v=%0h n=%0d exp v=0 n=0", out_valid, log_q.size()); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1; in_valid = 1'b1; in_data = mk(32'h77); in_ctrl = 3'b111;
    step();
    in_valid = 1'b0; in_ctrl = 3'b000;
    total++; if (out_valid !== 1'b1 || out_ctrl !== 3'b111)
      begin bad++; $display("FAIL bubble_load got v=%0h c=%0h exp v=1 c=7", out_valid, out_ctrl); end
    step();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 3'b000)
      begin bad++; $display("FAIL bubble_ctrl got v=%0h c=%0h exp v=0 c=0", out_valid, out_ctrl); end
  endtask

  task automatic test_noskid();
    s0_out_ready = 1'b0; s0_in_valid = 1'b1; s0_in_data = mk(32'hA1); s0_in_ctrl = 3'b001;
    #1;
    total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL ns_empty_ready got=%0h exp=1", s0_in_ready); end
    step();
    s0_in_data = mk(32'hA2); s0_in_ctrl = 3'b010;
    #1;
    total++; if (s0_out_valid !== 1'b1 || s0_out_data !== mk(32'hA1) || s0_in_ready !== 1'b0)
      begin bad++; $display("FAIL ns_stall got v=%0h d=%0h r=%0h exp v=1 d=a1 r=0", s0_out_valid, s0_out_data, s0_in_ready); end
    step();
    total++; if (s0_out_data !== mk(32'hA1) || s0_occupancy !== 2'd1)
      begin bad++; $display("FAIL ns_hold got d=%0h occ=%0d exp d=a1 occ=1", s0_out_data, s0_occupancy); end
    s0_out_ready = 1'b1;
    #1;
    total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL ns_comb_ready got=%0h exp=1", s0_in_ready); end
    step();
    s0_in_valid = 1'b0;
    total++; if (s0_out_valid !== 1'b1 || s0_out_data !== mk(32'hA2) || s0_out_ctrl !== 3'b010 || s0_occupancy !== 2'd1)
      begin bad++; $display("FAIL ns_pass got v=%0h d=%0h c=%0h occ=%0d exp v=1 d=a2 c=2 occ=1", s0_out_valid, s0_out_data, s0_out_ctrl, s0_occupancy); end
    step();
    total++; if (s0_out_valid !== 1'b0 || s0_out_ctrl !== 3'b000)
      begin bad++; $display("FAIL ns_drain got v=%0h c=%0h exp v=0 c=0", s0_out_valid, s0_out_ctrl); end
  endtask

  initial begin
    s0_in_valid = 1'b0; s0_in_data = '0; s0_in_ctrl = '0; s0_flush = 1'b0; s0_out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_bubble();
    test_noskid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Generic, parametrised inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble insertion.
- Replaces the fixed per-stage register files (IF/ID, ID/EX, EX/MEM, MEM/WB) so that any stage can stall or flush without corrupting in-flight state.
- Payload is split into two fields:
  - data: datapath values (ALU result, read data, PC+4, rd).
  - ctrl: side-effecting control bits (RegWrite, MemWrite, ResultSrc). These are forced to zero on bubbles and flushes.

Parameters:
- DATA_W, 101, width of the datapath payload (MEM/WB default: 3x32 + rd 5).
- CTRL_W, 3, width of the control payload (MEM/WB default: ResultSrc 2 + RegWrite 1).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream stage presents a valid instruction.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid & in_ready.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  kill all held and incoming entries (branch mispredict / trap).
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream consumes; a transfer occurs when out_valid & out_ready.
- out_data  out  DATA_W  held datapath payload.
- out_ctrl  out  CTRL_W  held control payload; always 0 when out_valid=0.
- occupancy  out  2  number of held entries (0..2); debug/perf use.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. After any clk edge with rst=1:
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - Skid entry invalid, skid data/ctrl = 0.
  - in_ready=1.
  - rst overrides flush and all handshakes, including mid-transfer.
- Storage (SKID=1): main register (drives outputs) plus skid register.
- States, encoded by occupancy:
  - EMPTY(0): in accept -> ONE; main<=in.
  - ONE(1):
    - in accept & out accept -> ONE; main<=in.
    - in accept & !out accept -> TWO; skid<=in.
    - out accept only -> EMPTY; main ctrl<=0.
    - neither -> hold.
  - TWO(2): in_ready=0.
    - out accept -> ONE; main<=skid; skid ctrl<=0.
    - else hold.
- in_ready (SKID=1): equals !skid_valid, driven from a flop.
  - No combinational path from out_ready to in_ready.
  - in_valid while in_ready=0 is not an accept; upstream must hold its values.
- SKID=0: single main register only.
  - in_ready = !out_valid | out_ready (combinational).
  - Same transfer rules as above, but TWO is unreachable.
- Latency and ordering:
  - 1 cycle from input accept to out_valid when EMPTY.
  - Sustained throughput 1 transfer/cycle with out_ready=1.
  - Strict FIFO order; no entry duplicated or dropped except by flush.
- Flush, at the clk edge with flush=1:
  - All valids cleared; main and skid ctrl set to 0; data fields hold their value.
  - A simultaneous input accept is discarded.
  - A simultaneous output accept still counts downstream, since it was combinationally visible that cycle.
  - Next cycle: occupancy=0, in_ready=1.
- Bubble invariant: out_valid=0 implies out_ctrl=0, so no register or memory write ever leaks from an invalid slot.
- out_data/out_ctrl change only on a load of the main register, a flush or rst. They must be stable while out_valid & !out_ready.
- X-safety: in_data and in_ctrl are ignored unless in_valid & in_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - Per-stage width constants: IFID/IDEX/EXMEM/MEMWB _DATA_W and _CTRL_W.
  - Field offset localparams for the MEM/WB packing: ALUResult[31:0], ReadData[63:32], PCPlus4[95:64], Rd[100:96]; ctrl RegWrite[0], ResultSrc[2:1].
  - A typedef for occupancy state.
- No sub-module is required.
- The main/skid slot logic may optionally be factored as pipe_slot (valid + data + ctrl flop with load/clear), instantiated twice.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_data=0xDEADBEEF -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; first accept after release appears at out_valid on the next cycle.
- Streaming: out_ready=1, 8 back-to-back inputs with data 1..8 and ctrl=3'b011 -> outputs 1..8 in order, one per cycle, 1-cycle latency, in_ready constantly 1.
- Backpressure/skid: ONE holding A=0x10; drop out_ready while accepting B=0x20:
  - Required: occupancy=2, in_ready=0 the following cycle, out_data stays 0x10.
  - Raise out_ready: 0x10 then 0x20 delivered; nothing lost or duplicated.
- Flush: occupancy=2 (entries 0x30, 0x40), pulse flush together with in_valid (0x50) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0x30, 0x40 and 0x50 never appear at the output.
- Bubble ctrl: accept ctrl=3'b111, consume it, no new input -> out_valid=0 and out_ctrl=3'b000 on the following cycle.
- SKID=0 build: out_valid=1 with out_ready=0 -> in_ready=0 in the same cycle; toggle out_ready=1 -> in_ready=1 combinationally and a pass-through transfer occurs at that clk edge.
